// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared constants and types for the mult_arbiter block.
//   MUL_LAT  : latency of the external pipelined multiplier (operands captured
//              at the end of the issue cycle, product visible MUL_LAT cycles on)
//   OP_W     : operand width
//   P_W      : product width
//   STAT_W   : width of the optional per-requester grant counters
//   ID_MAX_W : widest requester ID the tag can carry (NREQ up to 8)
//   tag_t    : {valid, id} record that follows an issued operand pair down
//              the multiplier pipeline
//   id_w()   : requester ID width, max(1, clog2(n))
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int MUL_LAT  = 3;
    localparam int OP_W     = 4;
    localparam int P_W      = 8;
    localparam int STAT_W   = 16;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// mult_arbiter_if
// Requester and response handshake bundle of mult_arbiter.
//   req_valid[NREQ]      requester -> arbiter, operand pair offered
//   req_a/req_b[NREQ*4]  requester -> arbiter, requester i at [4i+3:4i]
//   req_ready[NREQ]      arbiter -> requester, one-hot grant
//   rsp_valid            arbiter -> consumer, response FIFO head valid
//   rsp_id[IDW]          arbiter -> consumer, requester ID of the head
//   rsp_p[8]             arbiter -> consumer, product of the head
//   rsp_ready            consumer -> arbiter, head accepted
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source keeps its payload stable while
// valid is high and no transfer has happened; a requester may withdraw valid
// before being granted, which only forfeits that arbitration round. Ready may
// depend combinationally on valid; valid never depends on ready.
// Modports: master = requester/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = mult_arb_pkg::id_w(NREQ)
);
    import mult_arb_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [P_W-1:0]       rsp_p;
    logic                 rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req_i starting at ptr_i and grants
// the first requester found, wrapping modulo NREQ.
//   req_i[NREQ]  request vector
//   ptr_i[IDW]   highest-priority index for this cycle (always < NREQ)
//   en_i         grant permitted (credit available)
//   gnt_o[NREQ]  one-hot grant, all zero when disabled or nothing requested
//   idx_o[IDW]   encoded index of the grant (0 when none)
//   any_o        a grant was made
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_i) + 32'(k)) % 32'(NREQ);
            if (en_i && !found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = IDW'(cand);
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one external 3-stage pipelined 4x4 unsigned multiplier among NREQ
// requesters. One operand pair is issued per cycle in round-robin order; a tag
// pipeline matched to the multiplier latency carries the requester ID so the
// product can be written, tagged, into a response FIFO. Grants are credit
// limited so the FIFO can never overflow while the non-stallable multiplier
// still has products in flight.
// Parameters: NREQ (2..8), RSP_DEPTH (>=2, full rate needs >= MUL_LAT+1).
// Ports:
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   bus (slave)       requester and response handshakes (mult_arbiter_if)
//   mul_a, mul_b      operands to the multiplier, 0 when nothing is issued
//   mul_p             product from the multiplier, MUL_LAT cycles after issue
//   stat_sel          requester whose grant count is shown
//   stat_cnt          grant count of stat_sel
// Optional feature: define MULT_ARB_STATS_EN for saturating 16-bit grant
// counters per requester; without it stat_cnt is tied to 0.
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int RSP_DEPTH = 4,
    localparam int IDW       = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_arbiter_if.slave     bus,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [P_W-1:0]    mul_p,
    input  logic [IDW-1:0]    stat_sel,
    output logic [STAT_W-1:0] stat_cnt
);

    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int USED_W = $clog2(RSP_DEPTH + MUL_LAT + 1) + 1;

    // ------------------------------------------------------------------ state
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    tag_t                tag_q [MUL_LAT];
    tag_t                tag_d;
    logic [ID_MAX_W-1:0] fifo_id_q [RSP_DEPTH];
    logic [P_W-1:0]      fifo_p_q  [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // ------------------------------------------------------------ arbitration
    logic [NREQ-1:0]   grant_vec;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic              credit_ok;
    logic [USED_W-1:0] inflight;
    logic [USED_W-1:0] used;
    logic              push;
    logic              pop;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (credit_ok),
        .gnt_o (grant_vec),
        .idx_o (grant_idx),
        .any_o (grant_any)
    );

    assign bus.req_ready = grant_vec;

    // Credit counts every product already committed to land in the FIFO
    // (valid tags) plus what it holds. A pop in the same cycle frees a slot
    // early, which is what lets a grant resume in the cycle of the first pop.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            inflight = inflight + USED_W'(tag_q[s].valid);
        end
        used      = inflight + USED_W'(count_q) - USED_W'(pop);
        credit_ok = (used < USED_W'(RSP_DEPTH));
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant_any) begin
            mul_a = bus.req_a[int'(grant_idx)*OP_W +: OP_W];
            mul_b = bus.req_b[int'(grant_idx)*OP_W +: OP_W];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        tag_d    = '0;
        if (grant_any) begin
            rr_ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            tag_d.valid = 1'b1;
            tag_d.id    = ID_MAX_W'(grant_idx);
        end
    end

    // ----------------------------------------------------------- response FIFO
    assign push = tag_q[MUL_LAT-1].valid;
    assign pop  = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q[0] <= tag_d;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q] <= tag_q[MUL_LAT-1].id;
            fifo_p_q[wr_ptr_q]  <= mul_p;
        end
    end

    logic [ID_MAX_W-1:0] head_id;
    logic                unused_head;

    assign head_id       = fifo_id_q[rd_ptr_q];
    assign unused_head   = ^head_id;
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_id    = bus.rsp_valid ? head_id[IDW-1:0] : '0;
    assign bus.rsp_p     = bus.rsp_valid ? fifo_p_q[rd_ptr_q] : '0;

    // ---------------------------------------------------------- grant counters
`ifdef MULT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else if (grant_any && (stat_cnt_q[grant_idx] != '1)) begin
            stat_cnt_q[grant_idx] <= stat_cnt_q[grant_idx] + 1'b1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        if (int'(stat_sel) < NREQ) begin
            stat_cnt = stat_cnt_q[stat_sel];
        end
    end
`else
    logic unused_stat;

    assign unused_stat = ^stat_sel;
    assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Self-checking bench for mult_arbiter (NREQ=4, RSP_DEPTH=4). Provides a
// 3-stage unreset multiplier model, drives requesters from per-requester
// operand lists, and keeps a scoreboard of {id, a*b} in grant order.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = IDW + P_W;
    localparam int SRCN = 256;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ DUT
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [P_W-1:0]    mul_p;
    logic [IDW-1:0]    stat_sel;
    logic [STAT_W-1:0] stat_cnt;

    mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mult_arbiter #(
        .NREQ      (NREQ),
        .RSP_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt)
    );

    // Multiplier model: captures at the end of the issue cycle, product
    // visible three cycles later; no reset, like the real instance.
    logic [P_W-1:0] m1, m2, m3;

    always @(posedge clk) begin
        m1 <= {4'b0, mul_a} * {4'b0, mul_b};
        m2 <= m1;
        m3 <= m2;
    end

    assign mul_p = m3;

    // ------------------------------------------------------------ bench state
    int n_checks = 0;
    int n_pass   = 0;
    int n_rsp    = 0;
    int cyc      = 0;
    int model_ptr;

    logic [W-1:0]    exp_q[$];
    int              gnt_log[$];
    int              gnt_cyc[$];

    logic [OP_W-1:0] src_a [NREQ][SRCN];
    logic [OP_W-1:0] src_b [NREQ][SRCN];
    int              src_n [NREQ];
    int              src_h [NREQ];
    logic            auto_drv = 1'b0;
    logic            rand_rdy = 1'b0;
    logic            last_gnt_vld = 1'b0;
    int              last_gnt = 0;

    // ----------------------------------------------------------- driver tasks
    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_n[i] = 0;
            src_h[i] = 0;
        end
    endtask

    task automatic push_op(input int r, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        src_a[r][src_n[r]] = a;
        src_b[r][src_n[r]] = b;
        src_n[r]++;
    endtask

    task automatic refresh_req();
        for (int i = 0; i < NREQ; i++) begin
            if (src_h[i] < src_n[i]) begin
                bus.req_valid[i]            = 1'b1;
                bus.req_a[i*OP_W +: OP_W]   = src_a[i][src_h[i]];
                bus.req_b[i*OP_W +: OP_W]   = src_b[i][src_h[i]];
            end else begin
                bus.req_valid[i]            = 1'b0;
                bus.req_a[i*OP_W +: OP_W]   = '0;
                bus.req_b[i*OP_W +: OP_W]   = '0;
            end
        end
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_h[i] < src_n[i]) p = 1;
        end
        return p;
    endfunction

    // Scoreboard sampling, done at the falling edge of every cycle.
    task automatic sample();
        logic [OP_W-1:0] a, b;
        logic [P_W-1:0]  p;
        logic [W-1:0]    e, got;
        last_gnt_vld = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            return;
        end
        n_checks++;
        if (($countones(bus.req_ready) > 1) || ((bus.req_ready & ~bus.req_valid) != '0)) begin
            $display("FAIL grant_onehot: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
        end else begin
            n_pass++;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                a = bus.req_a[i*OP_W +: OP_W];
                b = bus.req_b[i*OP_W +: OP_W];
                p = {4'b0, a} * {4'b0, b};
                exp_q.push_back({IDW'(i), p});
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
                last_gnt_vld = 1'b1;
                last_gnt     = i;
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            got = {bus.rsp_id, bus.rsp_p};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got id=%0d p=%0d with nothing outstanding",
                         bus.rsp_id, bus.rsp_p);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    $display("FAIL rsp_data: got id=%0d p=%0d expected id=%0d p=%0d",
                             got[W-1:P_W], got[P_W-1:0], e[W-1:P_W], e[P_W-1:0]);
                end else begin
                    n_pass++;
                end
            end
            n_rsp++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        if (auto_drv) begin
            if (last_gnt_vld) src_h[last_gnt]++;
            refresh_req();
        end
        if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int max_cyc, input string name);
        int k = 0;
        while ((pending() || exp_q.size() != 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        n_checks++;
        if (pending() || exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d responses outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), k);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        stat_sel      = '0;
        clear_src();
        #2;
        n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); else n_pass++;
        n_checks++; if (mul_a !== 4'd0) $display("FAIL rst_mul_a: got %0d expected 0", mul_a); else n_pass++;
        n_checks++; if (mul_b !== 4'd0) $display("FAIL rst_mul_b: got %0d expected 0", mul_b); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL rst_rsp_id: got %0d expected 0", bus.rsp_id); else n_pass++;
        n_checks++; if (bus.rsp_p !== 8'd0) $display("FAIL rst_rsp_p: got %0d expected 0", bus.rsp_p); else n_pass++;
        n_checks++; if (stat_cnt !== 16'd0) $display("FAIL rst_stat_cnt: got %0d expected 0", stat_cnt); else n_pass++;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        model_ptr = 0;
    endtask

    task automatic test_single();
        bus.rsp_ready           = 1'b1;
        bus.req_valid           = 4'b0100;
        bus.req_a[2*OP_W +: OP_W] = 4'd13;
        bus.req_b[2*OP_W +: OP_W] = 4'd11;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", bus.req_ready); else n_pass++;
        n_checks++; if (mul_a !== 4'd13 || mul_b !== 4'd11) $display("FAIL single_mul_ops: got %0d,%0d expected 13,11", mul_a, mul_b); else n_pass++;
        cycle();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_rsp: cycle +%0d got rsp_valid=%b expected 0", k, bus.rsp_valid); else n_pass++;
            cycle();
        end
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_id !== 2'd2) $display("FAIL single_rsp_id: got %0d expected 2", bus.rsp_id); else n_pass++;
        n_checks++; if (bus.rsp_p !== 8'd143) $display("FAIL single_rsp_p: got %0d expected 143", bus.rsp_p); else n_pass++;
        cycle();
        drain(10, "single");
        model_ptr = 3;
    endtask

    task automatic test_round_robin();
        clear_src();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 6; k++) begin
                push_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        gnt_log.delete();
        gnt_cyc.delete();
        bus.rsp_ready = 1'b1;
        auto_drv      = 1'b1;
        refresh_req();
        drain(100, "rr");
        auto_drv = 1'b0;
        n_checks++; if (gnt_log.size() != 24) $display("FAIL rr_count: got %0d grants expected 24", gnt_log.size()); else n_pass++;
        for (int k = 0; k < gnt_log.size() && k < 24; k++) begin
            n_checks++;
            if (gnt_log[k] != (model_ptr + k) % NREQ) $display("FAIL rr_order: grant %0d got req %0d expected %0d", k, gnt_log[k], (model_ptr + k) % NREQ);
            else n_pass++;
            n_checks++;
            if (gnt_cyc[k] - gnt_cyc[0] != k) $display("FAIL rr_rate: grant %0d got cycle offset %0d expected %0d", k, gnt_cyc[k] - gnt_cyc[0], k);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] exp_rdy;
        clear_src();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 3; k++) begin
                push_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        gnt_log.delete();
        bus.rsp_ready = 1'b0;
        auto_drv      = 1'b1;
        refresh_req();
        repeat (12) cycle();
        n_checks++; if (gnt_log.size() != 4) $display("FAIL bp_grants: got %0d expected 4", gnt_log.size()); else n_pass++;
        for (int k = 0; k < gnt_log.size() && k < 4; k++) begin
            n_checks++;
            if (gnt_log[k] != (model_ptr + k) % NREQ) $display("FAIL bp_order: grant %0d got req %0d expected %0d", k, gnt_log[k], (model_ptr + k) % NREQ);
            else n_pass++;
        end
        #1;
        n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL bp_stalled: got req_ready=%b expected 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_fifo_valid: got %b expected 1", bus.rsp_valid); else n_pass++;
        bus.rsp_ready = 1'b1;
        #1;
        exp_rdy = '0;
        exp_rdy[model_ptr] = 1'b1;
        n_checks++; if (bus.req_ready !== exp_rdy) $display("FAIL bp_resume: got req_ready=%b expected %b", bus.req_ready, exp_rdy); else n_pass++;
        drain(100, "bp");
        auto_drv = 1'b0;
        n_checks++; if (gnt_log.size() != 12) $display("FAIL bp_total: got %0d grants expected 12", gnt_log.size()); else n_pass++;
    endtask

    task automatic test_exhaustive();
        int n0;
        clear_src();
        for (int k = 0; k < 256; k++) begin
            push_op(k % NREQ, 4'(k >> 4), 4'(k & 15));
        end
        n0       = n_rsp;
        auto_drv = 1'b1;
        rand_rdy = 1'b1;
        refresh_req();
        drain(3000, "exh");
        rand_rdy      = 1'b0;
        auto_drv      = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (6) cycle();
        n_checks++; if (n_rsp - n0 != 256) $display("FAIL exh_count: got %0d responses expected 256", n_rsp - n0); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int n0;
        clear_src();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 10; k++) begin
                push_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        bus.rsp_ready = 1'b1;
        auto_drv      = 1'b1;
        refresh_req();
        repeat (6) cycle();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_busy: got rsp_valid=%b expected 1", bus.rsp_valid); else n_pass++;
        rst_n    = 1'b0;
        auto_drv = 1'b0;
        clear_src();
        refresh_req();
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_cleared: got %b expected 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL mid_req_ready: got %b expected 0", bus.req_ready); else n_pass++;
        cycle();
        cycle();
        rst_n = 1'b1;
        n0    = n_rsp;
        repeat (8) cycle();
        n_checks++; if (n_rsp != n0) $display("FAIL mid_ghost: got %0d responses after reset expected 0", n_rsp - n0); else n_pass++;
        bus.req_valid = 4'b1111;
        bus.req_a     = 16'h7531;
        bus.req_b     = 16'h9ace;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", bus.req_ready); else n_pass++;
        cycle();
        bus.req_valid = '0;
        drain(20, "mid");
        model_ptr = 1;
    endtask

    task automatic test_stats();
`ifdef MULT_ARB_STATS_EN
        clear_src();
        for (int k = 0; k < 5; k++) push_op(1, 4'(k + 2), 4'(k + 7));
        bus.rsp_ready = 1'b1;
        auto_drv      = 1'b1;
        refresh_req();
        drain(40, "stat5");
        auto_drv = 1'b0;
        stat_sel = 2'd1;
        #1;
        n_checks++; if (stat_cnt !== 16'd5) $display("FAIL stat_req1: got %0d expected 5", stat_cnt); else n_pass++;
        stat_sel = 2'd0;
        #1;
        n_checks++; if (stat_cnt !== 16'd1) $display("FAIL stat_req0: got %0d expected 1", stat_cnt); else n_pass++;
        bus.req_valid             = 4'b0010;
        bus.req_a[1*OP_W +: OP_W] = 4'd3;
        bus.req_b[1*OP_W +: OP_W] = 4'd5;
        repeat (65535) cycle();
        bus.req_valid = '0;
        drain(20, "stat_sat");
        stat_sel = 2'd1;
        #1;
        n_checks++; if (stat_cnt !== 16'hFFFF) $display("FAIL stat_saturate: got %0h expected ffff", stat_cnt); else n_pass++;
`else
        for (int i = 0; i < NREQ; i++) begin
            stat_sel = IDW'(i);
            #1;
            n_checks++; if (stat_cnt !== 16'd0) $display("FAIL stat_disabled: sel %0d got %0d expected 0", i, stat_cnt); else n_pass++;
        end
`endif
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exhaustive();
        test_reset_midop();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
